// File: rtl/search_display_pkg.sv
// Shared FSM encoding, glyph constants and double-dabble helper for search_result_display.
package search_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_F     = 7'h0E;

  // Shift-add-3 correction applied to one BCD nibble before each shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational, no flow control.
module seg7_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/search_result_display.sv
// Captures search results on busy falling and shows status + decimal address on 4 seven-segment digits.
// Latency: hit 10 clocks, miss 2 clocks after capture; no backpressure, one-deep pending slot (newest wins).
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module search_result_display
  import search_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       busy,
  input  logic       match,
  input  logic [7:0] address,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       result_match,
  output logic       result_valid
);

  state_t      state;
  logic        busy_q;
  logic        pend;
  logic        pend_match;
  logic [7:0]  pend_addr;
  logic        hit_q;
  logic [19:0] shreg;
  logic [2:0]  cnt;

  logic        done_edge;
  logic [19:0] shreg_adj;
  logic [6:0]  seg_h, seg_t, seg_o;
  logic [6:0]  disp_h, disp_t;

  assign done_edge = busy_q & ~busy;

  // {hundreds, tens, ones, binary}; hundreds never exceeds 2 so nothing is lost off the top.
  assign shreg_adj = {dabble_adj(shreg[19:16]), dabble_adj(shreg[15:12]),
                      dabble_adj(shreg[11:8]), shreg[7:0]};

  seg7_decoder u_dec_h (.digit(shreg[19:16]), .seg(seg_h));
  seg7_decoder u_dec_t (.digit(shreg[15:12]), .seg(seg_t));
  seg7_decoder u_dec_o (.digit(shreg[11:8]),  .seg(seg_o));

`ifdef LEADING_ZERO_BLANK_EN
  assign disp_h = (shreg[19:16] == 4'd0) ? SEG_BLANK : seg_h;
  assign disp_t = (shreg[19:12] == 8'd0) ? SEG_BLANK : seg_t;
`else
  assign disp_h = seg_h;
  assign disp_t = seg_t;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy_q       <= 1'b0;
      pend         <= 1'b0;
      pend_match   <= 1'b0;
      pend_addr    <= 8'd0;
      hit_q        <= 1'b0;
      shreg        <= 20'd0;
      cnt          <= 3'd0;
      hex3         <= SEG_BLANK;
      hex2         <= SEG_BLANK;
      hex1         <= SEG_BLANK;
      hex0         <= SEG_BLANK;
      result_match <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      busy_q       <= busy;
      result_valid <= 1'b0;

      // A fresh capture beats a same-cycle dequeue, keeping pend set.
      if (done_edge) begin
        pend       <= 1'b1;
        pend_match <= match;
        pend_addr  <= address;
      end else if (state == ST_IDLE && pend) begin
        pend <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pend) begin
            hit_q <= pend_match;
            if (pend_match) begin
              shreg <= {12'd0, pend_addr};
              cnt   <= 3'd0;
              state <= ST_CONVERT;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_CONVERT: begin
          shreg <= {shreg_adj[18:0], 1'b0};
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (hit_q) begin
            hex3 <= SEG_F;
            hex2 <= disp_h;
            hex1 <= disp_t;
            hex0 <= seg_o;
          end else begin
            hex3 <= SEG_DASH;
            hex2 <= SEG_DASH;
            hex1 <= SEG_DASH;
            hex0 <= SEG_DASH;
          end
          result_match <= hit_q;
          result_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_search_result_display.sv
// Randomized bench for search_result_display against a timeline-level reference model.
module tb_search_result_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic       match;
  logic [7:0] address;
  logic [6:0] hex3, hex2, hex1, hex0;
  logic       result_match, result_valid;

  always #5 clk = ~clk;

  search_result_display dut (
    .clk(clk), .rst(rst), .busy(busy), .match(match), .address(address),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .result_match(result_match), .result_valid(result_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: capture slot, a server that frees at a known cycle,
  // and the cycle at which the next result becomes visible.
  int         cyc = 0;
  bit         m_busy_q;
  bit         m_pend, m_pm;
  logic [7:0] m_pa;
  int         m_free_at = 0;
  int         m_load_at = -1;
  bit         m_svc_match;
  logic [7:0] m_svc_addr;
  logic [6:0] e3 = 7'h7F, e2 = 7'h7F, e1 = 7'h7F, e0 = 7'h7F;
  bit         e_match, e_valid;
  int         pulses = 0;

  task automatic model_step();
    int h, t, o;
    if (rst) begin
      m_busy_q = 0; m_pend = 0; m_free_at = cyc + 1; m_load_at = -1;
      e3 = 7'h7F; e2 = 7'h7F; e1 = 7'h7F; e0 = 7'h7F;
      e_match = 0; e_valid = 0;
    end else begin
      e_valid = (cyc == m_load_at);
      if (e_valid) begin
        e_match = m_svc_match;
        if (m_svc_match) begin
          h = m_svc_addr / 100; t = (m_svc_addr / 10) % 10; o = m_svc_addr % 10;
          e3 = 7'h0E; e2 = seg_tab[h]; e1 = seg_tab[t]; e0 = seg_tab[o];
`ifdef LEADING_ZERO_BLANK_EN
          if (h == 0) e2 = 7'h7F;
          if (h == 0 && t == 0) e1 = 7'h7F;
`endif
        end else begin
          e3 = 7'h3F; e2 = 7'h3F; e1 = 7'h3F; e0 = 7'h3F;
        end
      end
      if (cyc >= m_free_at && m_pend) begin
        m_svc_match = m_pm; m_svc_addr = m_pa;
        m_load_at = cyc + (m_pm ? 9 : 1);
        m_free_at = m_load_at + 1;
        m_pend = 0;
      end
      if (m_busy_q && !busy) begin
        m_pend = 1; m_pm = match; m_pa = address;
      end
      m_busy_q = busy;
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("hex3", {25'd0, hex3}, {25'd0, e3});
    chk("hex2", {25'd0, hex2}, {25'd0, e2});
    chk("hex1", {25'd0, hex1}, {25'd0, e1});
    chk("hex0", {25'd0, hex0}, {25'd0, e0});
    chk("result_match", {31'd0, result_match}, {31'd0, e_match});
    chk("result_valid", {31'd0, result_valid}, {31'd0, e_valid});
    if (result_valid === 1'b1) pulses++;
    @(negedge clk);
  endtask

  task automatic search(input bit m, input logic [7:0] a);
    busy = 1; step();
    busy = 0; match = m; address = a; step();
  endtask

  initial begin
    int p0;
    rst = 1; busy = 0; match = 0; address = 8'd0;
    step();
    rst = 0;

    // busy low from reset: no edge, displays stay blank.
    p0 = pulses;
    for (int i = 0; i < 20; i++) step();
    chk("idle_no_valid", pulses - p0, 0);
    chk("idle_blank", {25'd0, hex0}, 32'h7F);

    // Hit 255.
    search(1, 8'd255);
    for (int i = 0; i < 10; i++) step();
    chk("h255_valid", {31'd0, result_valid}, 1);
    chk("h255_hex3", {25'd0, hex3}, 32'h0E);
    chk("h255_hex2", {25'd0, hex2}, 32'h24);
    chk("h255_hex1", {25'd0, hex1}, 32'h12);
    chk("h255_hex0", {25'd0, hex0}, 32'h12);
    step();
    chk("h255_pulse_one", {31'd0, result_valid}, 0);

    // Hit 7: leading-zero handling.
    search(1, 8'd7);
    for (int i = 0; i < 10; i++) step();
`ifdef LEADING_ZERO_BLANK_EN
    chk("h7_hex2", {25'd0, hex2}, 32'h7F);
    chk("h7_hex1", {25'd0, hex1}, 32'h7F);
`else
    chk("h7_hex2", {25'd0, hex2}, 32'h40);
    chk("h7_hex1", {25'd0, hex1}, 32'h40);
`endif
    chk("h7_hex0", {25'd0, hex0}, 32'h78);
    for (int i = 0; i < 3; i++) step();

    // Miss: dashes after 2 cycles.
    search(0, 8'd99);
    step(); step();
    chk("miss_valid", {31'd0, result_valid}, 1);
    chk("miss_hex3", {25'd0, hex3}, 32'h3F);
    chk("miss_match", {31'd0, result_match}, 0);
    for (int i = 0; i < 3; i++) step();

    // Second capture during CONVERT is queued, not lost.
    p0 = pulses;
    search(1, 8'd13);
    busy = 1; step(); step();
    busy = 0; address = 8'd200; step();
    for (int i = 0; i < 30; i++) step();
    chk("queued_pulses", pulses - p0, 2);
    chk("queued_last_hex2", {25'd0, hex2}, 32'h24);

    // Reset mid-CONVERT discards everything.
    search(1, 8'd123);
    step(); step(); step();
    rst = 1; step(); rst = 0;
    chk("rst_hex3", {25'd0, hex3}, 32'h7F);
    p0 = pulses;
    for (int i = 0; i < 15; i++) step();
    chk("rst_no_valid", pulses - p0, 0);

    // Random traffic with random gaps, overlapping captures and occasional reset.
    for (int k = 0; k < 150; k++) begin
      int bl, gl;
      bl = $urandom_range(1, 6);
      gl = $urandom_range(1, 14);
      busy = 1;
      for (int i = 0; i < bl; i++) begin
        match = 1'($urandom); address = 8'($urandom);
        step();
      end
      busy = 0;
      match = 1'($urandom); address = 8'($urandom);
      for (int i = 0; i < gl; i++) begin
        rst = ($urandom_range(0, 59) == 0);
        step();
        rst = 0;
      end
    end
    for (int i = 0; i < 25; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/search_result_display.md
# search_result_display

Downstream stage of the sequential ROM search block. It watches the search block's `busy`/`match`/`address` outputs and captures each result when `busy` falls. On a hit it converts the 8-bit address to three BCD digits with a multi-cycle shift-add-3 (double-dabble) engine, then drives four static active-low 7-segment displays: a status glyph plus the decimal address.

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `busy`  in  1  search-in-progress flag from the search block.
- `match`  in  1  search hit flag; valid when `busy` is low.
- `address`  in  8  hit address; valid only when `match`=1.
- `hex3`  out  7  status digit, segments {g,f,e,d,c,b,a}, active-low.
- `hex2`  out  7  hundreds digit, same encoding.
- `hex1`  out  7  tens digit.
- `hex0`  out  7  ones digit.
- `result_match`  out  1  last displayed result was a hit.
- `result_valid`  out  1  one-cycle pulse when new glyphs are loaded.

## Operation
- `busy_q` registers `busy` each cycle. The completion edge is `busy_q`=1 && `busy`=0.
- On the completion edge, latch `match` and `address` into `pend_match`/`pend_addr` and set `pend`=1. A later edge overwrites the pending capture (one-deep, newest wins).
- FSM states are IDLE, CONVERT, LOAD.
  - IDLE: if `pend`, clear `pend`. On a hit, load the shift register with `pend_addr`, clear BCD, set `cnt`=0, and go to CONVERT. On a miss, go to LOAD.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left 1. Increment `cnt`. After the 8th shift, go to LOAD.
  - LOAD: update the display registers, `result_match`, and `result_valid`=1, then return to IDLE.
- BCD is 12 bits (hundreds ≤2). `cnt` is 3 bits and wraps at 8.
- Hit display: `hex3`=F glyph 7'h0E; `hex2..hex0` show decimal digits via the digit decoder.
- Miss display: all four digits show dash 7'h3F; `address` is ignored.
- Display registers hold their value until the next LOAD.

## Timing
- Reset values: `hex3..hex0`=7'h7F (blank), `result_match`=0, `result_valid`=0. FSM=IDLE, `pend`=0, `busy_q`=0.
- Hit latency: completion edge at clock E0 (captured), E1 IDLE→CONVERT, E2..E9 eight shifts, E10 LOAD. Outputs update and `result_valid` rises after E10 and stay high for exactly one cycle.
- Miss latency: E0 capture, E1 IDLE→LOAD, E2 load.
- A completion edge arriving during CONVERT or LOAD is not lost. It is processed on the first IDLE cycle, and the current conversion is never aborted.
- A completion edge and an IDLE dequeue in the same cycle: the new capture wins. `pend` stays 1 and the dequeued data is the old capture.
- Reset mid-CONVERT: displays blank and pending/partial results are discarded.
- A `busy` level that is low from reset produces no edge, so the displays stay blank.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - hundreds digit is blank (7'h7F) when 0;
  - tens digit is blank when hundreds and tens are both 0;
  - ones digit is always shown.
- Not defined: all three digits are always shown (e.g. 007).
- Miss/status glyphs are unaffected in both cases.

## Structure
- Package `search_display_pkg` holds:
  - FSM state encodings;
  - glyph constants `SEG_BLANK`=7'h7F, `SEG_DASH`=7'h3F, `SEG_F`=7'h0E.
- Sub-module `seg7_decoder` is a 4-bit digit → active-low segment decoder. It is instantiated three times, once each for hundreds, tens and ones.

## Test plan
- Reset, then hold `busy`=0 for 20 cycles → all hex=7'h7F, `result_valid` never asserted.
- `busy` 1→0 with `match`=1, `address`=255 → 10 cycles later: `hex3`=0E, `hex2`=24, `hex1`=12, `hex0`=12, `result_match`=1, one-cycle `result_valid`.
- Hit at `address`=7:
  - macro undefined → `hex2`=40, `hex1`=40, `hex0`=78;
  - macro defined → `hex2`=7F, `hex1`=7F, `hex0`=78.
- `busy` 1→0 with `match`=0 → 2 cycles later all hex=3F, `result_match`=0.
- Hit on addr 13, then a second edge (hit, addr 200) 3 cycles later during CONVERT → first "F013" loads, then "F200" loads with two separate `result_valid` pulses.
- Assert `rst` for one cycle mid-CONVERT → all hex=7F next cycle and no `result_valid` follows.
